// File: rtl/opcap_pkg.sv
// ============================================================================
// opcap_pkg : shared types and defaults for reservation-station operand slots
// Rev 1.0
// ============================================================================
`default_nettype none

package opcap_pkg;

   localparam int TAG_W_DEFAULT  = 4;
   localparam int DATA_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      WAIT  = 2'b01,
      READY = 2'b10
   } opcap_state_e;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tag_match_prio_enc.sv
// ============================================================================
// tag_match_prio_enc : N-way tag compare with fixed-priority (index 0 first) winner
// Rev 1.0
// ============================================================================
`default_nettype none

module tag_match_prio_enc #(
   parameter int N     = 4,
   parameter int TAG_W = 4,
   parameter int SEL_W = 2
) (
   input  logic [N*TAG_W-1:0] tag_in,
   input  logic [N-1:0]       valid_in,
   input  logic [TAG_W-1:0]   cmp_tag_in,
   output logic               any_match_out,
   output logic               multi_match_out,
   output logic [SEL_W-1:0]   win_idx_out
);

   logic [N-1:0] w_match;

   for (genvar gi = 0; gi < N; gi++) begin : g_cmp
      assign w_match[gi] = valid_in[gi] && (tag_in[gi*TAG_W +: TAG_W] == cmp_tag_in);
   end

   logic w_seen;

   always_comb begin
      win_idx_out     = '0;
      multi_match_out = 1'b0;
      w_seen          = 1'b0;
      // Descending scan so the lowest matching index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            win_idx_out = SEL_W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         multi_match_out = multi_match_out | (w_seen & w_match[i]);
         w_seen          = w_seen | w_match[i];
      end
   end

   assign any_match_out = |w_match;

endmodule

`default_nettype wire

// File: rtl/operand_capture_sel.sv
// ============================================================================
// operand_capture_sel : one reservation-station operand slot with CDB capture
// Rev 1.0
// ============================================================================
`default_nettype none

module operand_capture_sel
   import opcap_pkg::*;
#(
   parameter int NUM_PIPES = 4,
   parameter int TAG_W     = TAG_W_DEFAULT,
   parameter int DATA_W    = DATA_W_DEFAULT,
   parameter int SEL_W     = clog2_min1(NUM_PIPES)
) (
   input  logic                        clk_in,
   input  logic                        reset_n_in,
   input  logic                        alloc_valid_in,
   input  logic [TAG_W-1:0]            alloc_tag_in,
   input  logic                        alloc_ready_in,
   input  logic [DATA_W-1:0]           alloc_data_in,
   input  logic [NUM_PIPES-1:0]        cdb_valid_in,
   input  logic [NUM_PIPES*TAG_W-1:0]  cdb_tag_in,
   input  logic [NUM_PIPES*DATA_W-1:0] cdb_data_in,
   input  logic                        issue_in,
   input  logic                        flush_in,
   input  logic                        clr_err_in,
   output logic                        busy_out,
   output logic                        operand_ready_out,
   output logic [DATA_W-1:0]           operand_data_out,
   output logic [SEL_W-1:0]            reg_data_mux_sel_out,
   output logic                        multi_match_err_out
);

   opcap_state_e      state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              err_q, err_d;

   logic              w_alloc_take;
   logic              w_eval;
   logic [TAG_W-1:0]  w_cmp_tag;
   logic              w_any_match;
   logic              w_multi_match;
   logic [SEL_W-1:0]  w_win_idx;
   logic [DATA_W-1:0] w_win_data;
   logic [DATA_W-1:0] w_cdb_data [NUM_PIPES];

   // An allocation lands from EMPTY, or from READY when the current operand issues.
   assign w_alloc_take = alloc_valid_in &&
                         ((state_q == EMPTY) || ((state_q == READY) && issue_in));
   assign w_eval       = (state_q == WAIT) || w_alloc_take;
   assign w_cmp_tag    = (state_q == WAIT) ? tag_q : alloc_tag_in;

   tag_match_prio_enc #(
      .N     (NUM_PIPES),
      .TAG_W (TAG_W),
      .SEL_W (SEL_W)
   ) u_match (
      .tag_in          (cdb_tag_in),
      .valid_in        (cdb_valid_in),
      .cmp_tag_in      (w_cmp_tag),
      .any_match_out   (w_any_match),
      .multi_match_out (w_multi_match),
      .win_idx_out     (w_win_idx)
   );

   for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_unpack
      assign w_cdb_data[gi] = cdb_data_in[gi*DATA_W +: DATA_W];
   end

   assign w_win_data = w_cdb_data[w_win_idx];

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      data_d  = data_q;
      sel_d   = sel_q;

      case (state_q)
         EMPTY: ;
         WAIT: begin
            if (w_any_match) begin
               state_d = READY;
               data_d  = w_win_data;
               sel_d   = w_win_idx;
            end
         end
         READY: begin
            if (issue_in) begin
               state_d = EMPTY;
               tag_d   = '0;
               data_d  = '0;
               sel_d   = '0;
            end
         end
         default: begin
            state_d = EMPTY;
            tag_d   = '0;
            data_d  = '0;
            sel_d   = '0;
         end
      endcase

      if (w_alloc_take) begin
         if (alloc_ready_in) begin
            state_d = READY;
            data_d  = alloc_data_in;
            sel_d   = '0;
         end else if (w_any_match) begin
            state_d = READY;
            data_d  = w_win_data;
            sel_d   = w_win_idx;
         end else begin
            state_d = WAIT;
            tag_d   = alloc_tag_in;
            data_d  = '0;
            sel_d   = '0;
         end
      end

      if (flush_in) begin
         state_d = EMPTY;
         tag_d   = '0;
         data_d  = '0;
         sel_d   = '0;
      end
   end

   // A multi-match set outranks a same-cycle clear; a flushed cycle's match is discarded.
   always_comb begin
      err_d = err_q;
      if (clr_err_in) begin
         err_d = 1'b0;
      end
      if (w_eval && w_multi_match && !flush_in) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q <= EMPTY;
         tag_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   assign busy_out             = (state_q == WAIT) || (state_q == READY);
   assign operand_ready_out    = (state_q == READY);
   assign operand_data_out     = data_q;
   assign reg_data_mux_sel_out = sel_q;
   assign multi_match_err_out  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_capture_sel.sv
// ============================================================================
// tb_operand_capture_sel : scoreboard bench for operand_capture_sel (4- and 8-pipe)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_operand_capture_sel;

   logic clk;
   logic rst_n;

   // 4-pipe, 32-bit instance
   logic        alloc_valid, alloc_ready, issue, flush, clr_err;
   logic [3:0]  alloc_tag;
   logic [31:0] alloc_data;
   logic [3:0]  cdb_valid;
   logic [15:0] cdb_tag;
   logic [127:0] cdb_data;
   logic        busy, op_ready, err;
   logic [31:0] op_data;
   logic [1:0]  sel;

   // 8-pipe, 64-bit instance
   logic        a8_valid;
   logic [3:0]  a8_tag;
   logic [7:0]  c8_valid;
   logic [31:0] c8_tag;
   logic [511:0] c8_data;
   logic        busy8, ready8, err8;
   logic [63:0] data8;
   logic [2:0]  sel8;

   operand_capture_sel dut (
      .clk_in               (clk),
      .reset_n_in           (rst_n),
      .alloc_valid_in       (alloc_valid),
      .alloc_tag_in         (alloc_tag),
      .alloc_ready_in       (alloc_ready),
      .alloc_data_in        (alloc_data),
      .cdb_valid_in         (cdb_valid),
      .cdb_tag_in           (cdb_tag),
      .cdb_data_in          (cdb_data),
      .issue_in             (issue),
      .flush_in             (flush),
      .clr_err_in           (clr_err),
      .busy_out             (busy),
      .operand_ready_out    (op_ready),
      .operand_data_out     (op_data),
      .reg_data_mux_sel_out (sel),
      .multi_match_err_out  (err)
   );

   operand_capture_sel #(.NUM_PIPES(8), .DATA_W(64)) dut8 (
      .clk_in               (clk),
      .reset_n_in           (rst_n),
      .alloc_valid_in       (a8_valid),
      .alloc_tag_in         (a8_tag),
      .alloc_ready_in       (1'b0),
      .alloc_data_in        (64'd0),
      .cdb_valid_in         (c8_valid),
      .cdb_tag_in           (c8_tag),
      .cdb_data_in          (c8_data),
      .issue_in             (1'b0),
      .flush_in             (1'b0),
      .clr_err_in           (1'b0),
      .busy_out             (busy8),
      .operand_ready_out    (ready8),
      .operand_data_out     (data8),
      .reg_data_mux_sel_out (sel8),
      .multi_match_err_out  (err8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  sel;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic took   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] s);
      exp_t e;
      e.data = d;
      e.sel  = s;
      exp_q.push_back(e);
   endtask

   task automatic clear_inputs();
      alloc_valid = 1'b0; alloc_ready = 1'b0; alloc_tag = '0; alloc_data = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
      issue = 1'b0; flush = 1'b0; clr_err = 1'b0;
      a8_valid = 1'b0; a8_tag = '0; c8_valid = '0; c8_tag = '0; c8_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic set_cdb(input int p, input logic [3:0] t, input logic [31:0] d);
      cdb_valid[p]        = 1'b1;
      cdb_tag[p*4 +: 4]   = t;
      cdb_data[p*32 +: 32] = d;
   endtask

   task automatic alloc(input logic [3:0] t, input logic rdy, input logic [31:0] d);
      alloc_valid = 1'b1;
      alloc_tag   = t;
      alloc_ready = rdy;
      alloc_data  = d;
   endtask

   // Records whether the edge just taken consumed the operand (back-to-back refill detection).
   initial begin
      forever begin
         @(posedge clk);
         took = issue && op_ready && !flush;
      end
   end

   // Monitor: a fresh operand is presented when READY is entered or refilled after an issue.
   initial begin
      logic prev_ready;
      exp_t e;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ready = 1'b0;
         end else begin
            if (op_ready && (!prev_ready || took)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_operand: got data %0h sel %0d, required none", op_data, sel);
               end else begin
                  e = exp_q.pop_front();
                  chk("operand_data", {32'd0, op_data}, {32'd0, e.data});
                  chk("operand_sel", {62'd0, sel}, {62'd0, e.sel});
               end
            end
            prev_ready = op_ready;
         end
      end
   end

   initial begin
      int guard;
      clear_inputs();
      rst_n = 1'b0;
      #12;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_ready", {63'd0, op_ready}, 64'd0);
      chk("reset_data", {32'd0, op_data}, 64'd0);
      chk("reset_sel", {62'd0, sel}, 64'd0);
      chk("reset_err", {63'd0, err}, 64'd0);
      chk("reset_sel8", {61'd0, sel8}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Wait-then-capture from pipe 2
      alloc(4'd5, 1'b0, 32'd0);
      step();
      chk("wait_busy", {63'd0, busy}, 64'd1);
      chk("wait_ready", {63'd0, op_ready}, 64'd0);
      step();
      set_cdb(2, 4'd5, 32'hCAFE);
      push(32'hCAFE, 2'd2);
      step();
      chk("capture_err", {63'd0, err}, 64'd0);
      issue = 1'b1;
      step();
      chk("issue_busy", {63'd0, busy}, 64'd0);
      chk("issue_data_zero", {32'd0, op_data}, 64'd0);

      // Same-cycle bypass from pipe 3
      alloc(4'd7, 1'b0, 32'd0);
      set_cdb(3, 4'd7, 32'h11);
      push(32'h11, 2'd3);
      step();
      issue = 1'b1;
      step();

      // Multi-match: pipes 1 and 3, lower index wins
      alloc(4'd9, 1'b0, 32'd0);
      step();
      set_cdb(1, 4'd9, 32'hAA);
      set_cdb(3, 4'd9, 32'hBB);
      push(32'hAA, 2'd1);
      step();
      chk("multi_err_set", {63'd0, err}, 64'd1);
      step();
      chk("multi_err_sticky", {63'd0, err}, 64'd1);

      // Back-to-back issue + ready allocation
      issue = 1'b1;
      alloc(4'd1, 1'b1, 32'h42);
      push(32'h42, 2'd0);
      step();
      chk("b2b_busy", {63'd0, busy}, 64'd1);
      chk("b2b_ready", {63'd0, op_ready}, 64'd1);
      issue = 1'b1;
      step();

      // New multi-match in the same cycle as clear: set wins
      alloc(4'd2, 1'b0, 32'd0);
      step();
      set_cdb(0, 4'd2, 32'h1);
      set_cdb(2, 4'd2, 32'h2);
      clr_err = 1'b1;
      push(32'h1, 2'd0);
      step();
      chk("clr_vs_set_err", {63'd0, err}, 64'd1);
      clr_err = 1'b1;
      step();
      chk("clr_err", {63'd0, err}, 64'd0);
      issue = 1'b1;
      step();

      // Ready allocation; later allocation without issue is ignored
      alloc(4'd8, 1'b1, 32'h1234);
      push(32'h1234, 2'd0);
      step();
      alloc(4'd8, 1'b1, 32'h99);
      step();
      chk("ready_alloc_ignored", {32'd0, op_data}, 64'h1234);
      issue = 1'b1;
      step();

      // Allocation in WAIT ignored; issue while not READY ignored
      alloc(4'd3, 1'b0, 32'd0);
      step();
      alloc(4'd6, 1'b1, 32'h5);
      issue = 1'b1;
      step();
      chk("wait_alloc_ignored", {63'd0, op_ready}, 64'd0);
      chk("wait_still_busy", {63'd0, busy}, 64'd1);
      set_cdb(1, 4'd3, 32'h33);
      push(32'h33, 2'd1);
      step();
      issue = 1'b1;
      step();

      // Flush beats a same-cycle match; later broadcast is lost
      alloc(4'd4, 1'b0, 32'd0);
      step();
      flush = 1'b1;
      set_cdb(0, 4'd4, 32'h77);
      step();
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_ready", {63'd0, op_ready}, 64'd0);
      chk("flush_sel", {62'd0, sel}, 64'd0);
      set_cdb(0, 4'd4, 32'h77);
      step();
      chk("lost_broadcast", {63'd0, busy}, 64'd0);

      // 8-pipe instance: pipe 7 wins
      a8_valid = 1'b1;
      a8_tag   = 4'hA;
      step();
      c8_valid[7]          = 1'b1;
      c8_tag[28 +: 4]      = 4'hA;
      c8_data[448 +: 64]   = 64'hDEAD_BEEF_0000_0001;
      alloc(4'd0, 1'b1, 32'h55);
      push(32'h55, 2'd0);
      step();
      chk("p8_ready", {63'd0, ready8}, 64'd1);
      chk("p8_sel", {61'd0, sel8}, 64'd7);
      chk("p8_data", data8, 64'hDEAD_BEEF_0000_0001);

      // Asynchronous reset mid-READY
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("areset_ready", {63'd0, op_ready}, 64'd0);
      chk("areset_data", {32'd0, op_data}, 64'd0);
      chk("areset_busy", {63'd0, busy}, 64'd0);
      chk("areset_ready8", {63'd0, ready8}, 64'd0);
      chk("areset_data8", data8, 64'd0);
      chk("areset_sel8", {61'd0, sel8}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_operands: got %0d outstanding, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
